// File: rtl/amplitude_ram_arbiter.sv
// Round-robin arbiter sharing the single-port amplitude RAM between two write
// and two read requesters, each buffered by its own FIFO; read data is routed back by tag.
module amplitude_ram_arbiter #(
    parameter int num_qubit   = 3,
    parameter int complex_bit = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int RAM_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alpha_wr_en,
    input  logic [num_qubit-1:0]     alpha_wr_addr,
    input  logic [2*complex_bit-1:0] alpha_wr_data,
    input  logic                     beta_wr_en,
    input  logic [num_qubit-1:0]     beta_wr_addr,
    input  logic [2*complex_bit-1:0] beta_wr_data,
    input  logic                     gen_rd_en,
    input  logic [num_qubit-1:0]     gen_rd_addr,
    input  logic                     beta_rd_en,
    input  logic [num_qubit-1:0]     beta_rd_addr,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [num_qubit-1:0]     ram_addr,
    output logic [2*complex_bit-1:0] ram_wdata,
    input  logic [2*complex_bit-1:0] ram_rdata,
    output logic                     gen_rd_valid,
    output logic [2*complex_bit-1:0] gen_rd_data,
    output logic                     beta_rd_valid,
    output logic [2*complex_bit-1:0] beta_rd_data,
    output logic [3:0]               overflow,
    output logic                     busy
);
    localparam int AW = num_qubit;
    localparam int DW = 2 * complex_bit;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [1:0]    ptr_reg;
    logic [3:0]    push_req;
    logic [3:0]    nonempty;
    logic [AW-1:0] push_addr [4];
    logic [DW-1:0] push_data [4];
    logic [AW-1:0] head_addr [4];
    logic [DW-1:0] head_data [4];
    logic          grant_vld;
    logic [1:0]    grant_idx;
    logic          rd_issue;
    logic [RAM_LATENCY-1:0] tag_vld_reg;
    logic [RAM_LATENCY-1:0] tag_beta_reg;
    logic          tag_busy;

    // Queue order: 0 alpha write, 1 beta write, 2 generator read, 3 beta read.
    assign push_req     = {beta_rd_en, gen_rd_en, beta_wr_en, alpha_wr_en};
    assign push_addr[0] = alpha_wr_addr;
    assign push_addr[1] = beta_wr_addr;
    assign push_addr[2] = gen_rd_addr;
    assign push_addr[3] = beta_rd_addr;
    assign push_data[0] = alpha_wr_data;
    assign push_data[1] = beta_wr_data;
    assign push_data[2] = '0;
    assign push_data[3] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [AW-1:0] addr_mem [FIFO_DEPTH];
            logic [DW-1:0] data_mem [FIFO_DEPTH];
            logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          ovf_reg;
            logic          pop;
            logic          push_ok;

            assign pop = grant_vld && (grant_idx == 2'(gi));
            // A full queue still accepts a push when its head leaves in the same cycle.
            assign push_ok = push_req[gi] && !flush && ((count_reg != FULL_CNT) || pop);

            always_ff @(posedge clk) begin
                if (push_ok) begin
                    addr_mem[wr_ptr_reg] <= push_addr[gi];
                    data_mem[wr_ptr_reg] <= push_data[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                    ovf_reg    <= 1'b0;
                end else if (flush) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                    ovf_reg    <= 1'b0;
                end else begin
                    if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    count_reg <= count_reg + CW'(push_ok) - CW'(pop);
                    if (push_req[gi] && !push_ok) ovf_reg <= 1'b1;
                end
            end

            assign nonempty[gi]  = (count_reg != '0);
            assign head_addr[gi] = addr_mem[rd_ptr_reg];
            assign head_data[gi] = data_mem[rd_ptr_reg];
            assign overflow[gi]  = ovf_reg;
        end
    endgenerate

    // First non-empty queue after the pointer wins; nothing is granted around a flush.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_reg;
        if (state_reg != FLUSH && !flush) begin
            for (int k = 1; k <= 4; k++) begin
                if (!grant_vld && nonempty[2'(ptr_reg + 2'(k))]) begin
                    grant_vld = 1'b1;
                    grant_idx = 2'(ptr_reg + 2'(k));
                end
            end
        end
    end

    assign ram_en    = grant_vld;
    assign ram_we    = grant_vld && !grant_idx[1];
    assign ram_addr  = grant_vld ? head_addr[grant_idx] : '0;
    assign ram_wdata = ram_we ? head_data[grant_idx] : '0;
    assign rd_issue  = grant_vld && grant_idx[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            ptr_reg <= 2'd3;
        else if (grant_vld) ptr_reg <= grant_idx;
    end

    generate
        for (gi = 0; gi < RAM_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        tag_vld_reg[gi]  <= 1'b0;
                        tag_beta_reg[gi] <= 1'b0;
                    end else begin
                        tag_vld_reg[gi]  <= rd_issue;
                        tag_beta_reg[gi] <= grant_idx[0];
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        tag_vld_reg[gi]  <= 1'b0;
                        tag_beta_reg[gi] <= 1'b0;
                    end else begin
                        tag_vld_reg[gi]  <= tag_vld_reg[gi-1];
                        tag_beta_reg[gi] <= tag_beta_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_rd_valid  <= 1'b0;
            gen_rd_data   <= '0;
            beta_rd_valid <= 1'b0;
            beta_rd_data  <= '0;
        end else begin
            gen_rd_valid  <= tag_vld_reg[RAM_LATENCY-1] && !tag_beta_reg[RAM_LATENCY-1];
            beta_rd_valid <= tag_vld_reg[RAM_LATENCY-1] &&  tag_beta_reg[RAM_LATENCY-1];
            if (tag_vld_reg[RAM_LATENCY-1] && !tag_beta_reg[RAM_LATENCY-1]) gen_rd_data  <= ram_rdata;
            if (tag_vld_reg[RAM_LATENCY-1] &&  tag_beta_reg[RAM_LATENCY-1]) beta_rd_data <= ram_rdata;
        end
    end

    // The return register is the last stage of the tag pipe: a read is in flight until it is delivered.
    assign tag_busy = (|tag_vld_reg) || gen_rd_valid || beta_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = FLUSH;
        end else begin
            case (state_reg)
                IDLE:    if (|nonempty) state_next = SERVE;
                SERVE:   if (!(|nonempty) && !grant_vld) state_next = IDLE;
                FLUSH:   if (!tag_busy) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE) || (|nonempty) || tag_busy;

endmodule
